// File: rtl/ifetch_buffer.sv
// Fetch queue between the PC unit, instruction memory and decode.
// Optional ALIGN_CHECK_EN: misaligned PCs become filled entries with dec_misalign.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pc_valid,
  input  logic [AW-1:0] pc_in,
  output logic          pc_ready,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [AW-1:0] dec_pc,
`ifdef ALIGN_CHECK_EN
  output logic          dec_misalign,
`endif
  output logic [DW-1:0] dec_instr
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DCW = $clog2(2 * DEPTH) + 1;

  logic [AW-1:0]    pc_q    [DEPTH];
  logic [DW-1:0]    instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [DCW-1:0]   drop_cnt;

  logic           space;
  logic           mis;
  logic           push;
  logic           pop;
  logic           fill_hit;
  logic [PW-1:0]  fill_idx;
  logic [PW-1:0]  scan;
  logic [CW-1:0]  unfilled;
  logic           take_rsp;
  logic           drop_rsp;
  logic [DCW-1:0] drop_sum;
  logic [DCW-1:0] drop_nxt;

  assign space = count < CW'(DEPTH);

`ifdef ALIGN_CHECK_EN
  logic [DEPTH-1:0] mis_q;
  assign mis          = pc_in[1:0] != 2'b00;
  assign dec_misalign = mis_q[rd_ptr];
  assign pc_ready     = mis ? (pc_valid & ~redirect & space & rst_n)
                            : (imem_req & imem_gnt);
`else
  assign mis      = 1'b0;
  assign pc_ready = imem_req & imem_gnt;
`endif

  assign imem_req  = pc_valid & ~redirect & space & ~mis & rst_n;
  assign imem_addr = pc_in;
  assign push      = pc_ready;

  assign dec_valid = (count != '0) & filled_q[rd_ptr];
  assign dec_pc    = pc_q[rd_ptr];
  assign dec_instr = instr_q[rd_ptr];
  assign pop       = dec_valid & dec_ready & ~redirect;

  // Oldest reserved-but-unfilled entry, plus how many are outstanding.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    unfilled = '0;
    scan     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan = rd_ptr + PW'(i);
      if (CW'(i) < count && !filled_q[scan]) begin
        unfilled = unfilled + CW'(1);
        if (!fill_hit) begin
          fill_hit = 1'b1;
          fill_idx = scan;
        end
      end
    end
  end

  assign take_rsp = imem_rvalid & (drop_cnt == '0) & fill_hit;
  assign drop_rsp = imem_rvalid & (drop_cnt != '0);
  assign drop_sum = drop_cnt + DCW'(unfilled);
  assign drop_nxt = (imem_rvalid && drop_sum != '0)
                  ? drop_sum - DCW'(1) : drop_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      filled_q <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= drop_nxt;
    end else begin
      if (take_rsp) begin
        instr_q[fill_idx]  <= imem_rdata;
        filled_q[fill_idx] <= 1'b1;
      end
      if (drop_rsp)
        drop_cnt <= drop_cnt - DCW'(1);
      if (push) begin
        pc_q[wr_ptr]     <= pc_in;
        instr_q[wr_ptr]  <= '0;
        filled_q[wr_ptr] <= mis;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mis_q <= '0;
    else if (push && !redirect)
      mis_q[wr_ptr] <= mis;
  end
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: stream, backpressure, redirects, reset.
// The bench plays instruction memory with hand-timed in-order responses.
module tb_ifetch_buffer;

  logic        clk;
  logic        rst_n;
  logic        pc_valid;
  logic [31:0] pc_in;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
`ifdef ALIGN_CHECK_EN
  logic        dec_misalign;
`endif

  int checks;
  int failures;

  ifetch_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_valid    (pc_valid),
    .pc_in       (pc_in),
    .pc_ready    (pc_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
`ifdef ALIGN_CHECK_EN
    .dec_misalign(dec_misalign),
`endif
    .dec_instr   (dec_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc,
                       input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic redir);
    pc_valid    = pv;
    pc_in       = pc;
    imem_gnt    = 1'b1;
    imem_rvalid = rv;
    imem_rdata  = rd;
    dec_ready   = rdy;
    redirect    = redir;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc_ready", 32'(pc_ready), 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    rst_n = 1'b1;

    // 1: streaming, one pair per cycle after a 2-cycle fill
    do_reset();
    drive(1, 32'h0, 0, 0, 1, 0);
    chk("s_req", 32'(imem_req), 32'd1);
    chk("s_addr", imem_addr, 32'h0);
    chk("s_pc_ready", 32'(pc_ready), 32'd1);
    step();
    drive(1, 32'h4, 1, 32'hA000_0000, 1, 0);
    chk("s_no_bypass", 32'(dec_valid), 32'd0);
    step();
    drive(1, 32'h8, 1, 32'hA000_0001, 1, 0);
    chk("s_v0", 32'(dec_valid), 32'd1);
    chk("s_pc0", dec_pc, 32'h0);
    chk("s_i0", dec_instr, 32'hA000_0000);
    step();
    drive(1, 32'hC, 1, 32'hA000_0002, 1, 0);
    chk("s_pc1", dec_pc, 32'h4);
    chk("s_i1", dec_instr, 32'hA000_0001);
    step();
    drive(0, 0, 1, 32'hA000_0003, 1, 0);
    chk("s_pc2", dec_pc, 32'h8);
    chk("s_i2", dec_instr, 32'hA000_0002);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("s_v3", 32'(dec_valid), 32'd1);
    chk("s_pc3", dec_pc, 32'hC);
    chk("s_i3", dec_instr, 32'hA000_0003);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("s_empty", 32'(dec_valid), 32'd0);

    // 2: backpressure fills the queue, issue resumes after first pop
    do_reset();
    drive(1, 32'h100, 0, 0, 0, 0);
    chk("b_req0", 32'(imem_req), 32'd1);
    step();
    drive(1, 32'h104, 1, 32'hB100, 0, 0);
    step();
    drive(1, 32'h108, 1, 32'hB104, 0, 0);
    step();
    drive(1, 32'h10C, 1, 32'hB108, 0, 0);
    chk("b_rdy3", 32'(pc_ready), 32'd1);
    step();
    drive(1, 32'h110, 1, 32'hB10C, 0, 0);
    chk("b_full_req", 32'(imem_req), 32'd0);
    chk("b_full_rdy", 32'(pc_ready), 32'd0);
    step();
    drive(1, 32'h110, 0, 0, 1, 0);
    chk("b_pop_blk", 32'(imem_req), 32'd0);
    chk("b_head", dec_pc, 32'h100);
    step();
    drive(1, 32'h110, 0, 0, 1, 0);
    chk("b_resume", 32'(pc_ready), 32'd1);
    chk("b_head2", dec_pc, 32'h104);
    step();
    drive(0, 0, 1, 32'hB110, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("b_last_pc", dec_pc, 32'h110);
    chk("b_last_i", dec_instr, 32'hB110);

    // 3: redirect with 3 in flight drops the next 3 responses
    do_reset();
    drive(1, 32'h200, 0, 0, 1, 0);
    step();
    drive(1, 32'h204, 0, 0, 1, 0);
    step();
    drive(1, 32'h208, 0, 0, 1, 0);
    step();
    drive(1, 32'h20C, 0, 0, 1, 1);
    chk("r_req_blk", 32'(imem_req), 32'd0);
    chk("r_rdy_blk", 32'(pc_ready), 32'd0);
    step();
    drive(1, 32'h40, 1, 32'hDEAD_0001, 1, 0);
    chk("r_new_req", 32'(pc_ready), 32'd1);
    step();
    drive(0, 0, 1, 32'hDEAD_0002, 1, 0);
    chk("r_drop1", 32'(dec_valid), 32'd0);
    step();
    drive(0, 0, 1, 32'hDEAD_0003, 1, 0);
    chk("r_drop2", 32'(dec_valid), 32'd0);
    step();
    drive(0, 0, 1, 32'hC040, 1, 0);
    chk("r_drop3", 32'(dec_valid), 32'd0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("r_v", 32'(dec_valid), 32'd1);
    chk("r_pc", dec_pc, 32'h40);
    chk("r_i", dec_instr, 32'hC040);

    // 4: redirect coincident with a response, 2 in flight
    do_reset();
    drive(1, 32'h300, 0, 0, 1, 0);
    step();
    drive(1, 32'h304, 0, 0, 1, 0);
    step();
    drive(0, 0, 1, 32'hDEAD_0300, 1, 1);
    step();
    drive(1, 32'h80, 1, 32'hDEAD_0304, 1, 0);
    step();
    drive(0, 0, 1, 32'hC080, 1, 0);
    chk("c_wait", 32'(dec_valid), 32'd0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("c_v", 32'(dec_valid), 32'd1);
    chk("c_pc", dec_pc, 32'h80);
    chk("c_i", dec_instr, 32'hC080);

    // 5: async reset with two buffered entries
    do_reset();
    drive(1, 32'h500, 0, 0, 0, 0);
    step();
    drive(1, 32'h504, 1, 32'hE500, 0, 0);
    step();
    drive(1, 32'h508, 1, 32'hE504, 0, 0);
    step();
    drive(1, 32'h50C, 0, 0, 0, 0);
    chk("a_v_pre", 32'(dec_valid), 32'd1);
    chk("a_pc_pre", dec_pc, 32'h500);
    rst_n = 1'b0;
    #1;
    chk("a_v", 32'(dec_valid), 32'd0);
    chk("a_req", 32'(imem_req), 32'd0);
    chk("a_pc", dec_pc, 32'd0);
    chk("a_i", dec_instr, 32'd0);
    rst_n = 1'b1;

`ifdef ALIGN_CHECK_EN
    // 6: misaligned PC becomes a filled entry without a memory request
    do_reset();
    drive(1, 32'h6, 0, 0, 1, 0);
    chk("m_req", 32'(imem_req), 32'd0);
    chk("m_rdy", 32'(pc_ready), 32'd1);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("m_v", 32'(dec_valid), 32'd1);
    chk("m_pc", dec_pc, 32'h6);
    chk("m_i", dec_instr, 32'd0);
    chk("m_flag", 32'(dec_misalign), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
